// File: rtl/simulador_caixa_agua_pkg.sv
// Shared definitions for the water tank simulator: state and fault encodings
// plus the default parameter values used by the top and its prescaler.
package simulador_pkg;

    typedef enum logic [1:0] {
        REPOUSO    = 2'd0,
        ENCHENDO   = 2'd1,
        ESVAZIANDO = 2'd2,
        SATURADO   = 2'd3
    } estadoTanque;

    typedef enum logic [1:0] {
        FALHA_NENHUMA     = 2'b00,
        FALHA_ALTO_PRESO1 = 2'b01,
        FALHA_MEDIO_PRESO0 = 2'b10,
        FALHA_BAIXO_PRESO0 = 2'b11
    } tipoFalha;

    localparam int TICK_DIV_PADRAO      = 1000;
    localparam int CAPACIDADE_PADRAO    = 100;
    localparam int LIMIAR_BAIXO_PADRAO  = 20;
    localparam int LIMIAR_MEDIO_PADRAO  = 50;
    localparam int LIMIAR_ALTO_PADRAO   = 90;
    localparam int TAXA_ENCHE_PADRAO    = 3;
    localparam int TAXA_GOTEJA_PADRAO   = 1;
    localparam int TAXA_ASPERSAO_PADRAO = 2;

endpackage

// File: rtl/simulador_caixa_agua_gerador_tick.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrapping cycle.
// A synchronous clear restarts the period regardless of the enable.
module gerador_tick
    import simulador_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_PADRAO
) (
    input  logic clock,
    input  logic resetN,
    input  logic habilita,
    input  logic limpa,
    output logic tick
);

    localparam int LARGURA = $clog2(TICK_DIV);
    localparam logic [LARGURA-1:0] ULTIMO = LARGURA'(TICK_DIV - 1);

    logic [LARGURA-1:0] contagem;

    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create simulation order races.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            contagem <= '0;
        end else if (limpa) begin
            contagem <= '0;
        end else if (habilita) begin
            contagem <= (contagem == ULTIMO) ? '0 : contagem + LARGURA'(1);
        end
    end

    assign tick = habilita && (contagem == ULTIMO);

endmodule

// File: rtl/simulador_caixa_agua.sv
// Water tank simulator: integrates inflow/drain rates once per tick, saturates
// the volume to [0, CAPACIDADE] and drives registered level sensors and alarms.
module simulador_caixa_agua
    import simulador_pkg::*;
#(
    parameter int TICK_DIV      = TICK_DIV_PADRAO,
    parameter int CAPACIDADE    = CAPACIDADE_PADRAO,
    parameter int LIMIAR_BAIXO  = LIMIAR_BAIXO_PADRAO,
    parameter int LIMIAR_MEDIO  = LIMIAR_MEDIO_PADRAO,
    parameter int LIMIAR_ALTO   = LIMIAR_ALTO_PADRAO,
    parameter int TAXA_ENCHE    = TAXA_ENCHE_PADRAO,
    parameter int TAXA_GOTEJA   = TAXA_GOTEJA_PADRAO,
    parameter int TAXA_ASPERSAO = TAXA_ASPERSAO_PADRAO
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       valvulaEntrada,
    input  logic       gotejamento,
    input  logic       aspersao,
    input  logic       pausa,
    input  logic       carregarNivel,
    input  logic [6:0] nivelInicial,
    input  logic [1:0] falhaSensor,
    output logic       highLevel,
    output logic       mediumLevel,
    output logic       lowLevel,
    output logic [6:0] volume,
    output logic [1:0] estado,
    output logic       transbordo,
    output logic       seco
);

    localparam logic [6:0] CAP     = 7'(CAPACIDADE);
    localparam logic [6:0] LIM_B   = 7'(LIMIAR_BAIXO);
    localparam logic [6:0] LIM_M   = 7'(LIMIAR_MEDIO);
    localparam logic [6:0] LIM_A   = 7'(LIMIAR_ALTO);
    localparam logic signed [8:0] ENCHE   = 9'(TAXA_ENCHE);
    localparam logic signed [8:0] GOTEJA  = 9'(TAXA_GOTEJA);
    localparam logic signed [8:0] ASPERSA = 9'(TAXA_ASPERSAO);

    logic              tick;
    logic [6:0]        volumeReg, volumeNext;
    estadoTanque       estadoReg, estadoNext;
    logic signed [8:0] liquido;
    logic signed [9:0] soma;
    logic              altoNext, medioNext, baixoNext;

    gerador_tick #(.TICK_DIV(TICK_DIV)) uGeradorTick (
        .clock    (clock),
        .resetN   (resetN),
        .habilita (!pausa),
        .limpa    (carregarNivel),
        .tick     (tick)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        volumeNext = volumeReg;
        estadoNext = estadoReg;
        liquido = (valvulaEntrada ? ENCHE : 9'sd0)
                - (gotejamento ? GOTEJA : 9'sd0)
                - (aspersao ? ASPERSA : 9'sd0);
        soma = $signed({3'b000, volumeReg}) + $signed({liquido[8], liquido});

        if (carregarNivel) begin
            volumeNext = (nivelInicial > CAP) ? CAP : nivelInicial;
            estadoNext = REPOUSO;
        end else if (tick) begin
            if (soma < 10'sd0) begin
                volumeNext = '0;
                estadoNext = SATURADO;
            end else if (soma > $signed({3'b000, CAP})) begin
                volumeNext = CAP;
                estadoNext = SATURADO;
            end else begin
                volumeNext = soma[6:0];
                if (liquido > 9'sd0)      estadoNext = ENCHENDO;
                else if (liquido < 9'sd0) estadoNext = ESVAZIANDO;
                else                      estadoNext = REPOUSO;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            volumeReg <= '0;
            estadoReg <= REPOUSO;
        end else begin
            volumeReg <= volumeNext;
            estadoReg <= estadoNext;
        end
    end

    // Fault injection forces one sensor in the same path the healthy value takes.
    always_comb begin
        baixoNext = (volumeReg >= LIM_B);
        medioNext = (volumeReg >= LIM_M);
        altoNext  = (volumeReg >= LIM_A);
        case (tipoFalha'(falhaSensor))
            FALHA_ALTO_PRESO1:  altoNext  = 1'b1;
            FALHA_MEDIO_PRESO0: medioNext = 1'b0;
            FALHA_BAIXO_PRESO0: baixoNext = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            highLevel   <= 1'b0;
            mediumLevel <= 1'b0;
            lowLevel    <= 1'b0;
            transbordo  <= 1'b0;
            seco        <= 1'b0;
        end else begin
            highLevel   <= altoNext;
            mediumLevel <= medioNext;
            lowLevel    <= baixoNext;
            transbordo  <= (volumeReg == CAP) && valvulaEntrada;
            seco        <= (volumeReg == 7'd0) && (gotejamento || aspersao);
        end
    end

    assign volume = volumeReg;
    assign estado = estadoReg;

endmodule

// File: tb/tb_simulador_caixa_agua.sv
// Scoreboard bench for simulador_caixa_agua: a behavioural tank model queues the
// expected outputs of every clock, and a monitor compares them on the falling edge.
module tb_simulador_caixa_agua;

    localparam int TICK = 4;
    localparam int CAP  = 100;

    typedef struct {
        int vol;
        int est;
        int hi;
        int mid;
        int lo;
        int trans;
        int seco;
    } esperado_t;

    logic       clock = 1'b0;
    logic       resetN;
    logic       valvulaEntrada, gotejamento, aspersao, pausa, carregarNivel;
    logic [6:0] nivelInicial;
    logic [1:0] falhaSensor;
    logic       highLevel, mediumLevel, lowLevel, transbordo, seco;
    logic [6:0] volume;
    logic [1:0] estado;

    int nChecks = 0;
    int nFalhas = 0;

    esperado_t fila[$];

    // Reference model state
    int mVol = 0, mCnt = 0, mEst = 0;
    int mHi = 0, mMid = 0, mLo = 0, mTrans = 0, mSeco = 0;

    simulador_caixa_agua #(.TICK_DIV(TICK)) dut (
        .clock          (clock),
        .resetN         (resetN),
        .valvulaEntrada (valvulaEntrada),
        .gotejamento    (gotejamento),
        .aspersao       (aspersao),
        .pausa          (pausa),
        .carregarNivel  (carregarNivel),
        .nivelInicial   (nivelInicial),
        .falhaSensor    (falhaSensor),
        .highLevel      (highLevel),
        .mediumLevel    (mediumLevel),
        .lowLevel       (lowLevel),
        .volume         (volume),
        .estado         (estado),
        .transbordo     (transbordo),
        .seco           (seco)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input int atual, input int esperado);
        nChecks++;
        if (atual != esperado) begin
            nFalhas++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
        end
    endtask

    // Tank behaviour at one rising edge, from the inputs held across that edge.
    task automatic atualizaModelo();
        int liquido, alvo;
        if (!resetN) begin
            mVol = 0; mCnt = 0; mEst = 0;
            mHi = 0; mMid = 0; mLo = 0; mTrans = 0; mSeco = 0;
        end else begin
            mLo  = (mVol >= 20) ? 1 : 0;
            mMid = (mVol >= 50) ? 1 : 0;
            mHi  = (mVol >= 90) ? 1 : 0;
            if (falhaSensor == 2'b01) mHi  = 1;
            if (falhaSensor == 2'b10) mMid = 0;
            if (falhaSensor == 2'b11) mLo  = 0;
            mTrans = (mVol == CAP && valvulaEntrada) ? 1 : 0;
            mSeco  = (mVol == 0 && (gotejamento || aspersao)) ? 1 : 0;
            if (carregarNivel) begin
                mVol = (int'(nivelInicial) > CAP) ? CAP : int'(nivelInicial);
                mCnt = 0;
                mEst = 0;
            end else if (!pausa) begin
                if (mCnt == TICK - 1) begin
                    mCnt = 0;
                    liquido = 3 * int'(valvulaEntrada) - 1 * int'(gotejamento) - 2 * int'(aspersao);
                    alvo = mVol + liquido;
                    if (alvo < 0) begin
                        mVol = 0; mEst = 3;
                    end else if (alvo > CAP) begin
                        mVol = CAP; mEst = 3;
                    end else begin
                        mVol = alvo;
                        mEst = (liquido > 0) ? 1 : (liquido < 0) ? 2 : 0;
                    end
                end else begin
                    mCnt++;
                end
            end
        end
    endtask

    // One clock: the inputs already set are applied, expectation is queued.
    task automatic passo();
        esperado_t e;
        @(posedge clock);
        atualizaModelo();
        e.vol = mVol; e.est = mEst; e.hi = mHi; e.mid = mMid; e.lo = mLo;
        e.trans = mTrans; e.seco = mSeco;
        fila.push_back(e);
        #1;
    endtask

    always @(negedge clock) begin
        esperado_t e;
        if (fila.size() != 0) begin
            e = fila.pop_front();
            check("sb_volume", int'(volume), e.vol);
            check("sb_estado", int'(estado), e.est);
            check("sb_highLevel", int'(highLevel), e.hi);
            check("sb_mediumLevel", int'(mediumLevel), e.mid);
            check("sb_lowLevel", int'(lowLevel), e.lo);
            check("sb_transbordo", int'(transbordo), e.trans);
            check("sb_seco", int'(seco), e.seco);
        end
    end

    initial begin
        resetN = 1'b0; valvulaEntrada = 1'b0; gotejamento = 1'b0; aspersao = 1'b0;
        pausa = 1'b0; carregarNivel = 1'b0; nivelInicial = '0; falhaSensor = 2'b00;
        repeat (3) passo();
        check("reset_volume", int'(volume), 0);
        check("reset_estado", int'(estado), 0);
        check("reset_sensors", int'({highLevel, mediumLevel, lowLevel}), 0);
        check("reset_alarms", int'({transbordo, seco}), 0);

        // Filling from empty: 3 units per tick until clipped at capacity
        resetN = 1'b1; valvulaEntrada = 1'b1;
        repeat (135) passo();
        check("fill_33ticks_volume", int'(volume), 99);
        check("fill_33ticks_estado", int'(estado), 1);
        passo();
        check("fill_34ticks_volume", int'(volume), 100);
        check("fill_34ticks_estado", int'(estado), 3);
        repeat (4) passo();
        check("fill_transbordo", int'(transbordo), 1);
        check("fill_highLevel", int'(highLevel), 1);

        // Draining past the medium threshold
        valvulaEntrada = 1'b0; gotejamento = 1'b1; aspersao = 1'b1;
        carregarNivel = 1'b1; nivelInicial = 7'd51;
        passo();
        carregarNivel = 1'b0;
        check("drain_load", int'(volume), 51);
        repeat (4) passo();
        check("drain_volume", int'(volume), 48);
        check("drain_estado", int'(estado), 2);
        check("drain_medium_lag", int'(mediumLevel), 1);
        passo();
        check("drain_medium_fall", int'(mediumLevel), 0);

        // Underflow clips to zero
        gotejamento = 1'b0; carregarNivel = 1'b1; nivelInicial = 7'd1;
        passo();
        carregarNivel = 1'b0;
        repeat (4) passo();
        check("empty_volume", int'(volume), 0);
        check("empty_estado", int'(estado), 3);
        passo();
        check("empty_seco", int'(seco), 1);

        // Medium sensor stuck at 0, then restored
        aspersao = 1'b0; falhaSensor = 2'b10; carregarNivel = 1'b1; nivelInicial = 7'd95;
        passo();
        carregarNivel = 1'b0;
        passo();
        check("fault_sensors", int'({highLevel, mediumLevel, lowLevel}), 3'b101);
        falhaSensor = 2'b00;
        passo();
        check("fault_restored", int'(mediumLevel), 1);

        // Pause freezes the volume; load still acts and clamps
        valvulaEntrada = 1'b1; pausa = 1'b1;
        repeat (20) passo();
        check("pause_volume", int'(volume), 95);
        carregarNivel = 1'b1; nivelInicial = 7'd120;
        passo();
        carregarNivel = 1'b0;
        check("pause_load_clamp", int'(volume), 100);
        check("pause_load_estado", int'(estado), 0);

        // Reset in the middle of a tick period
        pausa = 1'b0; valvulaEntrada = 1'b0; carregarNivel = 1'b1; nivelInicial = 7'd60;
        passo();
        carregarNivel = 1'b0;
        repeat (2) passo();
        resetN = 1'b0;
        passo();
        check("midreset_outputs",
              int'({volume, estado, highLevel, mediumLevel, lowLevel, transbordo, seco}), 0);
        resetN = 1'b1; valvulaEntrada = 1'b1;
        repeat (3) passo();
        check("midreset_before_tick", int'(volume), 0);
        passo();
        check("midreset_first_tick", int'(volume), 3);

        // Randomised traffic, commands held for a few clocks at a time
        for (int i = 0; i < 800; i++) begin
            resetN        = ($urandom_range(0, 149) != 0);
            carregarNivel = ($urandom_range(0, 39) == 0);
            nivelInicial  = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) begin
                valvulaEntrada = 1'($urandom_range(0, 1));
                gotejamento    = 1'($urandom_range(0, 1));
                aspersao       = 1'($urandom_range(0, 1));
                pausa          = ($urandom_range(0, 5) == 0);
                falhaSensor    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            end
            passo();
        end

        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFalhas);
        $finish;
    end

endmodule
